// File: rtl/pipe_ctrl_pkg.sv
// =============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared constants and state type for the RV32 pipeline hazard
//               controller (writeback selects, forwarding selects, FSM states).
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// =============================================================================
// Module      : fwd_unit
// Description : EX-operand forwarding compare for one source register;
//               MEM-stage result wins over WB, x0 is never forwarded.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] waddrM,
    input  logic       reg_wrM,
    input  logic [4:0] waddrW,
    input  logic       reg_wrW,
    output logic [1:0] fwd
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = reg_wrM & (waddrM != 5'd0) & (waddrM == rs);
    assign w_hit_w = reg_wrW & (waddrW != 5'd0) & (waddrW == rs);

    always_comb begin
        fwd = FWD_RF;
        if (w_hit_m) begin
            fwd = FWD_M;
        end else if (w_hit_w) begin
            fwd = FWD_W;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// =============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush/forward controller for the 5-stage RV32 pipeline
//               with a data-memory wait FSM and sticky timeout fault.
//               Define PIPE_HAZARD_PERF_EN to add stall/flush perf counters.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] waddrE,
    input  logic       reg_wrE,
    input  logic [1:0] wb_selE,
    input  logic [4:0] waddrM,
    input  logic       reg_wrM,
    input  logic [4:0] waddrW,
    input  logic       reg_wrW,
    input  logic       br_takenE,
    input  logic       dmem_reqM,
    input  logic       dmem_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       flush_wb,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       mem_fault
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_evt
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    mem_state_e       r_state;
    mem_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_fault_nxt;

    logic             w_timeout_hit;
    logic             w_mem_busy;
    logic             w_load_use;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic             w_stall_if, w_stall_id, w_stall_ex, w_stall_mem;
    logic             w_flush_id, w_flush_ex, w_flush_wb;

    assign w_timeout_hit = (r_state == MEM_WAIT) & (r_wait_cnt == C_CNT_LAST);
    assign w_mem_busy    = dmem_reqM & ~dmem_ack & ~w_timeout_hit;
    assign w_load_use    = reg_wrE & (wb_selE == WB_MEM) & (waddrE != 5'd0)
                         & ((waddrE == rs1D) | (waddrE == rs2D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            mem_fault  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            mem_fault  <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_fault_nxt = mem_fault;
        case (r_state)
            RUN: begin
                if (dmem_reqM & ~dmem_ack) begin
                    w_state_nxt = MEM_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    w_state_nxt = RUN;
                end else if (w_timeout_hit) begin
                    // Access is abandoned; fault stays set until reset.
                    w_state_nxt = RUN;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_flush_wb  = 1'b0;
        if (w_mem_busy) begin
            // A taken branch stays frozen in EX and redirects on release.
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_stall_ex  = 1'b1;
            w_stall_mem = 1'b1;
            w_flush_wb  = 1'b1;
        end else begin
            w_flush_wb = w_timeout_hit;
            if (br_takenE) begin
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end else if (w_load_use) begin
                w_stall_if = 1'b1;
                w_stall_id = 1'b1;
                w_flush_ex = 1'b1;
            end
        end
    end

    fwd_unit u_fwd_a (
        .rs      (rs1E),
        .waddrM  (waddrM),
        .reg_wrM (reg_wrM),
        .waddrW  (waddrW),
        .reg_wrW (reg_wrW),
        .fwd     (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs      (rs2E),
        .waddrM  (waddrM),
        .reg_wrM (reg_wrM),
        .waddrW  (waddrW),
        .reg_wrW (reg_wrW),
        .fwd     (w_fwd_b)
    );

    assign stall_if  = rst & w_stall_if;
    assign stall_id  = rst & w_stall_id;
    assign stall_ex  = rst & w_stall_ex;
    assign stall_mem = rst & w_stall_mem;
    assign flush_id  = rst & w_flush_id;
    assign flush_ex  = rst & w_flush_ex;
    assign flush_wb  = rst & w_flush_wb;
    assign fwd_a     = rst ? w_fwd_a : FWD_RF;
    assign fwd_b     = rst ? w_fwd_b : FWD_RF;

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cyc <= '0;
            perf_flush_evt <= '0;
        end else begin
            if (stall_if | stall_id | stall_ex | stall_mem) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (flush_ex) begin
                perf_flush_evt <= perf_flush_evt + 32'd1;
            end
        end
    end
`else
    // Performance counters not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// =============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl
//               (MEM_TIMEOUT=4); honours PIPE_HAZARD_PERF_EN if defined.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, waddrE, waddrM, waddrW;
    logic       reg_wrE, reg_wrM, reg_wrW, br_takenE, dmem_reqM, dmem_ack;
    logic [1:0] wb_selE;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, mem_fault;
    logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_evt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .waddrE(waddrE), .reg_wrE(reg_wrE), .wb_selE(wb_selE),
        .waddrM(waddrM), .reg_wrM(reg_wrM),
        .waddrW(waddrW), .reg_wrW(reg_wrW),
        .br_takenE(br_takenE), .dmem_reqM(dmem_reqM), .dmem_ack(dmem_ack),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
        .flush_wb(flush_wb), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fault(mem_fault)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_flush_evt(perf_flush_evt)
`endif
    );

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
    function automatic logic [6:0] ctl();
        return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0;
        waddrE = 0; waddrM = 0; waddrW = 0;
        reg_wrE = 0; reg_wrM = 0; reg_wrW = 0; wb_selE = WB_ALU;
        br_takenE = 0; dmem_reqM = 0; dmem_ack = 0;
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        // Forwarding match present during reset must be masked.
        waddrM = 5'd7; reg_wrM = 1'b1; rs1E = 5'd7;
        #3;
        chk("reset_ctl",   {25'd0, ctl()}, 32'h00);
        chk("reset_fwd_a", {30'd0, fwd_a}, 32'h0);
        chk("reset_fault", {31'd0, mem_fault}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Forwarding priority and x0 exclusion
        waddrW = 5'd7; reg_wrW = 1'b1; rs2E = 5'd3; #1;
        chk("fwd_a_M", {30'd0, fwd_a}, 32'h1);
        chk("fwd_b_none", {30'd0, fwd_b}, 32'h0);
        reg_wrM = 1'b0; #1;
        chk("fwd_a_W", {30'd0, fwd_a}, 32'h2);
        waddrW = 5'd3; rs1E = 5'd0; #1;
        chk("fwd_b_W", {30'd0, fwd_b}, 32'h2);
        waddrW = 5'd0; rs2E = 5'd0; #1;
        chk("fwd_b_x0", {30'd0, fwd_b}, 32'h0);
        clear_in();

        // Load-use
        reg_wrE = 1'b1; wb_selE = WB_MEM; waddrE = 5'd5; rs1D = 5'd5; #1;
        chk("lu_stall", {25'd0, ctl()}, 32'h62);
        tick();
        waddrE = 5'd9; #1;
        chk("lu_release", {25'd0, ctl()}, 32'h00);
        waddrE = 5'd0; rs1D = 5'd0; #1;
        chk("lu_x0", {25'd0, ctl()}, 32'h00);
        waddrE = 5'd6; rs2D = 5'd6; wb_selE = WB_ALU; #1;
        chk("lu_alu", {25'd0, ctl()}, 32'h00);
        wb_selE = WB_MEM; #1;
        chk("lu_rs2", {25'd0, ctl()}, 32'h62);
        clear_in();
        tick();

        // Memory wait: 3 busy cycles then ack
        dmem_reqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_busy%0d", i), {25'd0, ctl()}, 32'h79);
            tick();
        end
        dmem_ack = 1'b1; #1;
        chk("mw_ack", {25'd0, ctl()}, 32'h00);
        tick();
        dmem_ack = 1'b1; #1;
        chk("mw_zero_wait", {25'd0, ctl()}, 32'h00);
        tick();
        dmem_reqM = 1'b0; dmem_ack = 1'b0; #1;
        chk("mw_stay_run", {25'd0, ctl()}, 32'h00);
        tick();

        // Branch held during a 2-cycle wait, plus load-use on release
        dmem_reqM = 1'b1; br_takenE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("br_hold%0d", i), {25'd0, ctl()}, 32'h79);
            tick();
        end
        dmem_ack = 1'b1;
        reg_wrE = 1'b1; wb_selE = WB_MEM; waddrE = 5'd4; rs1D = 5'd4; #1;
        chk("br_release", {25'd0, ctl()}, 32'h06);
        tick();
        clear_in();
        tick();

        // Timeout: 4 stalled cycles, then release with flush_wb
        dmem_reqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_busy%0d", i), {25'd0, ctl()}, 32'h79);
            tick();
        end
        #1;
        chk("to_release", {25'd0, ctl()}, 32'h01);
        chk("to_fault_pre", {31'd0, mem_fault}, 32'h0);
        tick();
        dmem_reqM = 1'b0; #1;
        chk("to_fault", {31'd0, mem_fault}, 32'h1);
        chk("to_idle", {25'd0, ctl()}, 32'h00);
        tick(); tick();
        chk("to_fault_sticky", {31'd0, mem_fault}, 32'h1);

        // Async reset mid-wait
        dmem_reqM = 1'b1;
        waddrM = 5'd8; reg_wrM = 1'b1; rs2E = 5'd8;
        tick(); tick();
        #1;
        chk("ar_waiting", {25'd0, ctl()}, 32'h79);
        rst = 1'b0; #1;
        chk("ar_ctl", {25'd0, ctl()}, 32'h00);
        chk("ar_fwd_b", {30'd0, fwd_b}, 32'h0);
        chk("ar_fault", {31'd0, mem_fault}, 32'h0);
        clear_in();
        @(negedge clk);
        rst = 1'b1;
        tick();
        // Fresh RUN state: a new unacked request needs 4 stall cycles to time out.
        dmem_reqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("ar_busy%0d", i), {25'd0, ctl()}, 32'h79);
            tick();
        end
        #1;
        chk("ar_timeout", {25'd0, ctl()}, 32'h01);
        clear_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
